reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port issue_valid, input, 1, decode stage presents an instruction.
REQ-004 SHALL have port issue_we, input, 1, the presented instruction writes issue_rd.
REQ-005 SHALL have port issue_rd, input, 5, destination register of the presented instruction.
REQ-006 SHALL have ports rs and rt, input, 5 each, source register indices of the presented instruction.
REQ-007 SHALL have ports use_rs and use_rt, input, 1 each, the presented instruction reads rs or rt.
REQ-008 SHALL have ports wb_valid (input, 1) and wb_rd (input, 5), a register file write completing this cycle.
REQ-009 SHALL have ports flush_req (input, 1) and flush_done (output, 1), the drain handshake.
REQ-010 SHALL have port stall, output, 1, combinational: the presented instruction must not issue.
REQ-011 SHALL have port pending, output, 32, one bit per register with a write outstanding.
REQ-012 SHALL have port busy_count, output, 6, registered count of set pending bits.
REQ-013 SHALL have port err_wb_unmatched, output, 1, sticky: writeback seen to a non-pending register.

Function
REQ-014 SHALL implement FSM states RUN, DRAIN and DONE.
REQ-015 SHALL move RUN->DRAIN on flush_req=1.
REQ-016 SHALL move DRAIN->DONE in the first cycle that busy_count==0 (or on the flush_req edge itself if already 0).
REQ-017 SHALL move DONE->RUN when flush_req=0.
REQ-018 SHALL assert flush_done=1 only in DONE.
REQ-019 SHALL compute hazard = (use_rs & pending[rs]) | (use_rt & pending[rt]) | (issue_we & pending[issue_rd]), the last term being WAW.
REQ-020 SHALL assert stall = issue_valid & (hazard | state!=RUN).
REQ-021 SHALL accept an issue in a cycle with issue_valid=1 and stall=0.
REQ-022 SHALL set pending[issue_rd] on the next edge when an accepted issue has issue_we=1.
REQ-023 SHALL clear pending[wb_rd] on the next edge when wb_valid=1 and that bit is set.
REQ-024 SHALL, when wb_valid=1 targets a clear bit, leave pending unchanged and set err_wb_unmatched.
REQ-025 SHALL give set priority over clear when the same register is set and cleared in one cycle (pending stays 1, busy_count unchanged).
REQ-026 SHALL update busy_count by +1, -1 or 0 per edge and keep it equal to popcount(pending); it never wraps (max 32, min 0).
REQ-027 SHALL treat register 0 as an ordinary writable register with no hardwired zero.
REQ-028 SHALL update the scoreboard on posedge, so that the register file write on the following negedge of the same cycle sees consistent data.
REQ-029 SHALL continue to accept writebacks in DRAIN and DONE; issues are blocked there.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force pending=0, busy_count=0, err_wb_unmatched=0, state=RUN and flush_done=0.
REQ-031 SHALL, on reset asserted mid-DRAIN, discard the drain; no flush_done is produced for that request.
REQ-032 SHALL have stall depend only on inputs after reset (pending is 0).

Configuration
REQ-033 SHALL use macro SCOREBOARD_WB_BYPASS_EN; when defined, a hazard term whose register equals wb_rd with wb_valid=1 in the same cycle is ignored for stall.
REQ-034 SHALL, with SCOREBOARD_WB_BYPASS_EN defined, still honour REQ-025 when the issue re-targets the register being cleared.
REQ-035 SHALL, without SCOREBOARD_WB_BYPASS_EN, stall until the cycle after the clear edge.

Verification
REQ-036 SHALL check: issue rd=7 we=1, next cycle rs=7 use_rs=1 -> stall=1, pending[7]=1, busy_count=1.
REQ-037 SHALL check: with rd=7 pending, wb_valid=1 wb_rd=7 plus issue rs=7 in the same cycle -> stall=0 with the macro, stall=1 without; pending[7]=0 after the edge.
REQ-038 SHALL check: issue rd=3 while pending[3]=1 (WAW) -> stall=1; issue rd=3 concurrent with a wb to 3 under the macro -> pending[3] stays 1, busy_count unchanged.
REQ-039 SHALL check: wb_valid=1 wb_rd=12 with pending=0 -> err_wb_unmatched=1, remaining 1 until rst_n=0.
REQ-040 SHALL check: pending rd=5 and rd=9, then flush_req=1 -> stall=1 for any issue; flush_done=1 one edge after the second wb clears; flush_req=0 -> RUN.
REQ-041 SHALL check: rst_n=0 asynchronously mid-DRAIN with busy_count=2 -> immediate pending=0, busy_count=0, flush_done=0, state RUN.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding register writes and stalls hazarding issues.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback resolve a hazard.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        stall,
    output logic [31:0] pending,
    output logic [5:0]  busy_count,
    output logic        err_wb_unmatched
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pending;
    logic [31:0] w_pendingNext;
    logic [5:0]  r_busy;
    logic        r_err;

    logic w_hzRs;
    logic w_hzRt;
    logic w_hzWaw;
    logic w_hazard;
    logic w_accept;
    logic w_set;
    logic w_clr;
    logic w_inc;
    logic w_dec;

    // A writeback landing this cycle clears its bit at the same edge the issue would be taken.
    always_comb begin
        w_hzRs  = use_rs & r_pending[rs];
        w_hzRt  = use_rt & r_pending[rt];
        w_hzWaw = issue_we & r_pending[issue_rd];
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && (wb_rd == rs))       w_hzRs  = 1'b0;
        if (wb_valid && (wb_rd == rt))       w_hzRt  = 1'b0;
        if (wb_valid && (wb_rd == issue_rd)) w_hzWaw = 1'b0;
`endif
        w_hazard = w_hzRs | w_hzRt | w_hzWaw;
    end

    assign stall    = issue_valid & (w_hazard | (r_state != RUN));
    assign w_accept = issue_valid & ~stall;
    assign w_set    = w_accept & issue_we;
    assign w_clr    = wb_valid & r_pending[wb_rd];

    // Set wins over clear on the same register, so that case is a net zero change.
    assign w_inc = w_set & ~r_pending[issue_rd];
    assign w_dec = w_clr & ~(w_set & (issue_rd == wb_rd));

    always_comb begin
        w_pendingNext = r_pending;
        if (w_clr) w_pendingNext[wb_rd]    = 1'b0;
        if (w_set) w_pendingNext[issue_rd] = 1'b1;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            RUN:     if (flush_req) w_stateNext = (r_busy == 6'd0) ? DONE : DRAIN;
            DRAIN:   if (r_busy == 6'd0) w_stateNext = DONE;
            DONE:    if (!flush_req) w_stateNext = RUN;
            default: w_stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_pending <= 32'd0;
            r_busy    <= 6'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pending <= w_pendingNext;
            if (w_inc && !w_dec)      r_busy <= r_busy + 6'd1;
            else if (w_dec && !w_inc) r_busy <= r_busy - 6'd1;
            if (wb_valid && !r_pending[wb_rd]) r_err <= 1'b1;
        end
    end

    assign flush_done       = (r_state == DONE);
    assign pending          = r_pending;
    assign busy_count       = r_busy;
    assign err_wb_unmatched = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: vector table plus hand-written reset/drain/fill sequences.
// Expectations follow SCOREBOARD_WB_BYPASS_EN when it is defined for the build.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rs;
    logic        use_rt;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush_req;
    logic        flush_done;
    logic        stall;
    logic [31:0] pending;
    logic [5:0]  busy_count;
    logic        err_wb_unmatched;

    reg_scoreboard dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid      (issue_valid),
        .issue_we         (issue_we),
        .issue_rd         (issue_rd),
        .rs               (rs),
        .rt               (rt),
        .use_rs           (use_rs),
        .use_rt           (use_rt),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .flush_req        (flush_req),
        .flush_done       (flush_done),
        .stall            (stall),
        .pending          (pending),
        .busy_count       (busy_count),
        .err_wb_unmatched (err_wb_unmatched)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic        we;
        logic [4:0]  rd;
        logic [4:0]  rsV;
        logic        urs;
        logic [4:0]  rtV;
        logic        urt;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        expStall;
        logic [31:0] expPending;
        logic [5:0]  expBusy;
        logic        expErr;
        logic        expDone;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] pend;
        logic [5:0]  busy;
        logic        err;
        logic        done;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[23];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] bitOf(input int r);
        return 32'h1 << r;
    endfunction

    function automatic vec_t mkVec(input logic iv, input logic we, input logic [4:0] rd,
                                   input logic [4:0] rsV, input logic urs,
                                   input logic [4:0] rtV, input logic urt,
                                   input logic wbv, input logic [4:0] wbrd, input logic fl,
                                   input logic st, input logic [31:0] pend,
                                   input logic [5:0] busy, input logic err, input logic done);
        vec_t v;
        v.iv = iv; v.we = we; v.rd = rd; v.rsV = rsV; v.urs = urs; v.rtV = rtV; v.urt = urt;
        v.wbv = wbv; v.wbrd = wbrd; v.fl = fl; v.expStall = st; v.expPending = pend;
        v.expBusy = busy; v.expErr = err; v.expDone = done;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        issue_valid = 0; issue_we = 0; issue_rd = 0; rs = 0; rt = 0;
        use_rs = 0; use_rt = 0; wb_valid = 0; wb_rd = 0; flush_req = 0;
    endtask

    // Drives one cycle of stimulus, checks stall, queues the post-edge expectation.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        issue_valid = v.iv; issue_we = v.we; issue_rd = v.rd;
        rs = v.rsV; use_rs = v.urs; rt = v.rtV; use_rt = v.urt;
        wb_valid = v.wbv; wb_rd = v.wbrd; flush_req = v.fl;
        #3;
        checkVal({tag, ".stall"}, {31'd0, stall}, {31'd0, v.expStall});
        e.tag = tag; e.pend = v.expPending; e.busy = v.expBusy; e.err = v.expErr; e.done = v.expDone;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checkVal("queue.empty", 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkVal({e.tag, ".pending"}, pending, e.pend);
        checkVal({e.tag, ".busy"}, {26'd0, busy_count}, {26'd0, e.busy});
        checkVal({e.tag, ".err"}, {31'd0, err_wb_unmatched}, {31'd0, e.err});
        checkVal({e.tag, ".done"}, {31'd0, flush_done}, {31'd0, e.done});
    endtask

    task automatic step(input vec_t v, input string tag);
        applyStimulus(v, tag);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] mask;
        string tag;

        // iv we rd  rs urs rt urt wbv wbrd fl  stall pending busy err done
        vecs[0]  = mkVec(1,1,7,  0,0,0,0, 0,0, 0, 0, bitOf(7), 1,0,0);
        vecs[1]  = mkVec(1,0,0,  7,1,0,0, 0,0, 0, 1, bitOf(7), 1,0,0);
        vecs[2]  = mkVec(1,0,0,  7,1,0,0, 1,7, 0, BYP ? 1'b0 : 1'b1, 32'd0, 0,0,0);
        vecs[3]  = mkVec(1,1,3,  0,0,0,0, 0,0, 0, 0, bitOf(3), 1,0,0);
        vecs[4]  = mkVec(1,1,3,  0,0,0,0, 0,0, 0, 1, bitOf(3), 1,0,0);
        vecs[5]  = mkVec(1,1,3,  0,0,0,0, 1,3, 0, BYP ? 1'b0 : 1'b1,
                         BYP ? bitOf(3) : 32'd0, BYP ? 6'd1 : 6'd0, 0,0);
        vecs[6]  = mkVec(1,1,3,  0,0,0,0, 0,0, 0, BYP ? 1'b1 : 1'b0, bitOf(3), 1,0,0);
        vecs[7]  = mkVec(0,0,0,  0,0,0,0, 1,3, 0, 0, 32'd0, 0,0,0);
        vecs[8]  = mkVec(1,1,0,  0,0,0,0, 0,0, 0, 0, bitOf(0), 1,0,0);
        vecs[9]  = mkVec(1,1,1,  0,0,5,1, 1,0, 0, 0, bitOf(1), 1,0,0);
        vecs[10] = mkVec(0,0,0,  0,0,0,0, 1,1, 0, 0, 32'd0, 0,0,0);
        vecs[11] = mkVec(0,0,0,  0,0,0,0, 1,12,0, 0, 32'd0, 0,1,0);
        vecs[12] = mkVec(1,1,5,  0,0,0,0, 0,0, 0, 0, bitOf(5), 1,1,0);
        vecs[13] = mkVec(1,1,9,  0,0,0,0, 0,0, 0, 0, bitOf(5) | bitOf(9), 2,1,0);
        vecs[14] = mkVec(0,0,0,  0,0,0,0, 0,0, 1, 0, bitOf(5) | bitOf(9), 2,1,0);
        vecs[15] = mkVec(1,1,20, 0,0,0,0, 0,0, 1, 1, bitOf(5) | bitOf(9), 2,1,0);
        vecs[16] = mkVec(0,0,0,  0,0,0,0, 1,5, 1, 0, bitOf(9), 1,1,0);
        vecs[17] = mkVec(0,0,0,  0,0,0,0, 1,9, 1, 0, 32'd0, 0,1,0);
        vecs[18] = mkVec(1,0,0,  0,0,0,0, 0,0, 1, 1, 32'd0, 0,1,1);
        vecs[19] = mkVec(1,0,0,  0,0,0,0, 0,0, 1, 1, 32'd0, 0,1,1);
        vecs[20] = mkVec(1,0,0,  0,0,0,0, 0,0, 0, 1, 32'd0, 0,1,0);
        vecs[21] = mkVec(1,1,20, 0,0,0,0, 0,0, 0, 0, bitOf(20), 1,1,0);
        vecs[22] = mkVec(0,0,0,  0,0,0,0, 1,20,0, 0, 32'd0, 0,1,0);

        driveIdle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkVal("reset.pending", pending, 32'd0);
        checkVal("reset.busy", {26'd0, busy_count}, 32'd0);
        checkVal("reset.err", {31'd0, err_wb_unmatched}, 32'd0);
        checkVal("reset.done", {31'd0, flush_done}, 32'd0);
        issue_valid = 1; issue_we = 1; issue_rd = 4; use_rs = 1; rs = 2; use_rt = 1; rt = 31;
        #1;
        checkVal("reset.stall", {31'd0, stall}, 32'd0);
        driveIdle();
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) step(vecs[i], $sformatf("v%0d", i));

        // Reset asserted in the middle of a drain with two writes outstanding.
        step(mkVec(1,1,5, 0,0,0,0, 0,0, 0, 0, bitOf(5), 1,1,0), "rd.a");
        step(mkVec(1,1,9, 0,0,0,0, 0,0, 0, 0, bitOf(5) | bitOf(9), 2,1,0), "rd.b");
        step(mkVec(0,0,0, 0,0,0,0, 0,0, 1, 0, bitOf(5) | bitOf(9), 2,1,0), "rd.flush");
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("rstDrain.pending", pending, 32'd0);
        checkVal("rstDrain.busy", {26'd0, busy_count}, 32'd0);
        checkVal("rstDrain.done", {31'd0, flush_done}, 32'd0);
        checkVal("rstDrain.err", {31'd0, err_wb_unmatched}, 32'd0);
        issue_valid = 1; issue_we = 1; issue_rd = 5;
        #1;
        checkVal("rstDrain.stall", {31'd0, stall}, 32'd0);
        driveIdle();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(mkVec(0,0,0, 0,0,0,0, 0,0, 0, 0, 32'd0, 0,0,0), "postRst.a");
        step(mkVec(0,0,0, 0,0,0,0, 0,0, 0, 0, 32'd0, 0,0,0), "postRst.b");

        // Flush with nothing outstanding goes straight to DONE.
        step(mkVec(0,0,0, 0,0,0,0, 0,0, 1, 0, 32'd0, 0,0,1), "fastFlush");
        step(mkVec(1,0,0, 0,0,0,0, 0,0, 0, 1, 32'd0, 0,0,0), "fastRelease");

        // Fill every register, then drain them all back out.
        mask = 32'd0;
        for (int r = 0; r < 32; r++) begin
            mask = mask | bitOf(r);
            tag = $sformatf("fill%0d", r);
            step(mkVec(1,1,r[4:0], 0,0,0,0, 0,0, 0, 0, mask, 6'(r + 1), 0,0), tag);
        end
        step(mkVec(1,0,0, 17,1,0,0, 0,0, 0, 1, mask, 32, 0,0), "full.raw");
        for (int r = 31; r >= 0; r--) begin
            mask = mask & ~bitOf(r);
            tag = $sformatf("empty%0d", r);
            step(mkVec(0,0,0, 0,0,0,0, 1,r[4:0], 0, 0, mask, 6'(r), 0,0), tag);
        end

        checkVal("queue.drained", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
